// File: rtl/display_pkg.sv
// Shared constants for the action/count 7-segment display: segment bit positions,
// active-high glyph patterns (bit 0 = a ... bit 6 = g) and a width helper.
package display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_A_HEX = 7'h77;
  localparam logic [6:0] SEG_B_HEX = 7'h7C;
  localparam logic [6:0] SEG_C_HEX = 7'h39;
  localparam logic [6:0] SEG_D_HEX = 7'h5E;
  localparam logic [6:0] SEG_E_HEX = 7'h79;
  localparam logic [6:0] SEG_F_HEX = 7'h71;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-glyph decoder; output is active-high, polarity is applied by the caller.
module seg_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_en,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    unique case (value)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = hex_en ? SEG_A_HEX : SEG_DASH;
      4'hB: pattern = hex_en ? SEG_B_HEX : SEG_DASH;
      4'hC: pattern = hex_en ? SEG_C_HEX : SEG_DASH;
      4'hD: pattern = hex_en ? SEG_D_HEX : SEG_DASH;
      4'hE: pattern = hex_en ? SEG_E_HEX : SEG_DASH;
      4'hF: pattern = hex_en ? SEG_F_HEX : SEG_DASH;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_acao_multiplex.sv
// Time-multiplexed N-digit 7-segment scan engine with shadow-loaded contents,
// per-digit blank/blink and a dark dead cycle at the start of every digit slot.
module display_acao_multiplex
  import display_pkg::*;
#(
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 12500000,
  parameter int HEX_EN      = 1,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic [4*N_DIG-1:0]                   digits_in,
  input  logic [N_DIG-1:0]                     blank_in,
  input  logic [N_DIG-1:0]                     blink_in,
  output logic [6:0]                           seg,
  output logic [N_DIG-1:0]                     dig_en,
  output logic [clog2_min1(N_DIG)-1:0]         scan_idx
);

  localparam int IDX_W = clog2_min1(N_DIG);
  localparam int PRE_W = clog2_min1(REFRESH_DIV);
  localparam int BLK_W = clog2_min1(BLINK_DIV);

  localparam logic [6:0]       SEG_MASK = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIG-1:0] DIG_MASK = (DIG_ACT_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  logic [PRE_W-1:0]   prescaler_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [BLK_W-1:0]   blink_cnt_reg;
  logic               blink_phase_reg;
  logic [4*N_DIG-1:0] digits_reg;
  logic [N_DIG-1:0]   blank_reg;
  logic [N_DIG-1:0]   blink_reg;
  logic [6:0]         seg_reg;
  logic [N_DIG-1:0]   dig_en_reg;
  logic [IDX_W-1:0]   scan_idx_reg;

  logic [3:0]       nibble_arr [N_DIG];
  logic [N_DIG-1:0] dark_vec;
  logic [N_DIG-1:0] onehot_vec;

  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
      assign nibble_arr[gi] = digits_reg[4*gi +: 4];
      assign dark_vec[gi]   = blank_reg[gi] | (blink_reg[gi] & ~blink_phase_reg);
      assign onehot_vec[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  logic [3:0] cur_nibble;
  logic       cur_dark;

  always_comb begin
    cur_nibble = 4'h0;
    cur_dark   = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (onehot_vec[k]) begin
        cur_nibble = nibble_arr[k];
        cur_dark   = dark_vec[k];
      end
    end
  end

  logic [6:0] pattern;

  seg_hex_decoder u_decoder (
    .value   (cur_nibble),
    .hex_en  (HEX_EN != 0),
    .pattern (pattern)
  );

  // Dead cycle and dark digits both blank the bus; the slot is still consumed.
  logic             visible;
  logic [6:0]       seg_next;
  logic [N_DIG-1:0] dig_en_next;
  logic             pre_wrap;
  logic             blk_wrap;

  assign visible     = (prescaler_reg != '0) && !cur_dark;
  assign seg_next    = visible ? pattern : SEG_OFF;
  assign dig_en_next = visible ? onehot_vec : '0;
  assign pre_wrap    = (prescaler_reg == PRE_W'(REFRESH_DIV - 1));
  assign blk_wrap    = (blink_cnt_reg == BLK_W'(BLINK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_reg   <= '0;
      idx_reg         <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
      digits_reg      <= '0;
      blank_reg       <= '0;
      blink_reg       <= '0;
      seg_reg         <= SEG_OFF ^ SEG_MASK;
      dig_en_reg      <= DIG_MASK;
      scan_idx_reg    <= '0;
    end else begin
      prescaler_reg <= pre_wrap ? '0 : prescaler_reg + PRE_W'(1);
      if (pre_wrap) begin
        idx_reg <= (idx_reg == IDX_W'(N_DIG - 1)) ? '0 : idx_reg + IDX_W'(1);
      end
      blink_cnt_reg <= blk_wrap ? '0 : blink_cnt_reg + BLK_W'(1);
      if (blk_wrap) begin
        blink_phase_reg <= ~blink_phase_reg;
      end
      if (load) begin
        digits_reg <= digits_in;
        blank_reg  <= blank_in;
        blink_reg  <= blink_in;
      end
      seg_reg      <= seg_next ^ SEG_MASK;
      dig_en_reg   <= dig_en_next ^ DIG_MASK;
      scan_idx_reg <= idx_reg;
    end
  end

  assign seg      = seg_reg;
  assign dig_en   = dig_en_reg;
  assign scan_idx = scan_idx_reg;

endmodule

// File: tb/tb_display_acao_multiplex.sv
// Drives three display configurations with shared stimulus and checks every cycle
// against a timing model computed from edge counts since reset.
module tb_display_acao_multiplex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [3:0]  blink_in;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] den_a, den_b;
  logic [0:0] den_c;
  logic [1:0] idx_a, idx_b;
  logic [0:0] idx_c;

  display_acao_multiplex #(
    .N_DIG(4), .REFRESH_DIV(4), .BLINK_DIV(16), .HEX_EN(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut_a (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in),
    .blank_in(blank_in), .blink_in(blink_in), .seg(seg_a), .dig_en(den_a), .scan_idx(idx_a)
  );

  display_acao_multiplex #(
    .N_DIG(4), .REFRESH_DIV(4), .BLINK_DIV(16), .HEX_EN(0), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
  ) dut_b (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in),
    .blank_in(blank_in), .blink_in(blink_in), .seg(seg_b), .dig_en(den_b), .scan_idx(idx_b)
  );

  display_acao_multiplex #(
    .N_DIG(1), .REFRESH_DIV(3), .BLINK_DIV(5), .HEX_EN(1), .SEG_ACT_LOW(0), .DIG_ACT_LOW(1)
  ) dut_c (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in[3:0]),
    .blank_in(blank_in[0:0]), .blink_in(blink_in[0:0]), .seg(seg_c), .dig_en(den_c), .scan_idx(idx_c)
  );

  int vectors = 0;
  int miscompares = 0;
  int ecount = 0;
  logic [15:0] sh_dig = '0;
  logic [3:0]  sh_blank = '0;
  logic [3:0]  sh_blink = '0;

  string seg_letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] letters_to_seg(input string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] decode(input int v, input int hexen);
    if (v > 9 && hexen == 0) return letters_to_seg("g");
    return letters_to_seg(seg_letters[v]);
  endfunction

  // Expected active-high outputs after the current edge, from the pre-edge edge count.
  function automatic void model(input int n, input int r, input int b, input int hexen,
                                output logic [6:0] s_ah, output logic [7:0] d_ah, output int idx);
    int  p, v;
    bit  vis_phase, dark;
    p         = ecount % r;
    idx       = (ecount / r) % n;
    vis_phase = ((ecount / b) % 2) == 0;
    v         = int'(sh_dig[idx*4 +: 4]);
    dark      = sh_blank[idx] || (sh_blink[idx] && !vis_phase);
    if (p == 0 || dark) begin
      s_ah = '0;
      d_ah = '0;
    end else begin
      s_ah = decode(v, hexen);
      d_ah = 8'(1) << idx;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic ld, input logic [15:0] dg,
                      input logic [3:0] bl, input logic [3:0] bk);
    logic [6:0] sa, sb, sc, ea, ec;
    logic [7:0] da, db, dc;
    logic [3:0] eda;
    logic [0:0] edc;
    int ia, ib, ic;
    @(negedge clk);
    reset = rst_v; load = ld; digits_in = dg; blank_in = bl; blink_in = bk;
    @(posedge clk);
    #1;
    if (rst_v) begin
      chk("rst_seg_a", seg_a, 7'h7F); chk("rst_den_a", den_a, 4'hF); chk("rst_idx_a", idx_a, 0);
      chk("rst_seg_b", seg_b, 7'h00); chk("rst_den_b", den_b, 4'h0); chk("rst_idx_b", idx_b, 0);
      chk("rst_seg_c", seg_c, 7'h00); chk("rst_den_c", den_c, 1'b1); chk("rst_idx_c", idx_c, 0);
      ecount = 0; sh_dig = '0; sh_blank = '0; sh_blink = '0;
    end else begin
      model(4, 4, 16, 1, sa, da, ia);
      model(4, 4, 16, 0, sb, db, ib);
      model(1, 3, 5, 1, sc, dc, ic);
      ea = ~sa; eda = ~da[3:0]; edc = ~dc[0:0];
      chk("seg_a", seg_a, ea); chk("den_a", den_a, eda); chk("idx_a", idx_a, ia);
      chk("seg_b", seg_b, sb); chk("den_b", den_b, db[3:0]); chk("idx_b", idx_b, ib);
      ec = sc;
      chk("seg_c", seg_c, ec); chk("den_c", den_c, edc); chk("idx_c", idx_c, ic);
      if (ia == 0 && da != 0 && sh_dig[3:0] == 4'hB) begin
        chk("hexB_a", seg_a, 7'b0000011);
        chk("dashB_b", seg_b, 7'b1000000);
      end
      if (ld) begin
        sh_dig = dg; sh_blank = bl; sh_blink = bk;
      end
      ecount++;
    end
    chk("onehot_a", ($countones(~den_a) <= 1), 1);
    chk("onehot_b", ($countones(den_b) <= 1), 1);
  endtask

  initial begin
    bit found;
    reset = 1'b1; load = 1'b0; digits_in = '0; blank_in = '0; blink_in = '0;
    // Reset, then scan digits 0..3 showing 0,1,2,3.
    repeat (3) step(1, 0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 16'h3210, 4'h0, 4'h0);
    repeat (40) step(0, 0, 16'h0, 4'h0, 4'h0);
    // Hex B versus dash on digit 0.
    step(0, 1, 16'h765B, 4'h0, 4'h0);
    repeat (20) step(0, 0, 16'h0, 4'h0, 4'h0);
    // Blank digit 2.
    step(0, 1, 16'h9A8C, 4'b0100, 4'h0);
    repeat (20) step(0, 0, 16'h0, 4'h0, 4'h0);
    // Blink digit 0 from a fresh reset.
    step(1, 0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 16'h4321, 4'h0, 4'b0001);
    repeat (80) step(0, 0, 16'h0, 4'h0, 4'h0);
    // Random contents with loads landing anywhere in a slot.
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));
    end
    // Reset asserted at idx=2, prescaler=3.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (ecount % 4 == 3 && (ecount / 4) % 4 == 2) found = 1'b1;
      else step(0, 0, 16'h0, 4'h0, 4'h0);
    end
    chk("reach_mid_slot", found, 1'b1);
    step(1, 0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 16'hFEDC, 4'h0, 4'h0);
    repeat (20) step(0, 0, 16'h0, 4'h0, 4'h0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0), 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
